fsm_flow_ctrl_multi: RTL and testbench
======================================

// Module: fsm_flow_ctrl_multi
// PURPOSE
//  Multi-channel flow-control state machine; parametrised successor of the single-FIFO flow-control FSM.
//  Watches almost_full/full/almost_empty/empty flags of NUM_CH FIFOs and issues one global
//  continuar/pausa/idle/error_full decision, plus a sticky per-channel full-error map.
//  Sits between the FIFO bank and the upstream producer, in the flowControl block group.
// PARAMETERS
//  NUM_CH     4   number of monitored FIFO channels (>=1)
//  PAUSE_TMO  16  max consecutive PAUSE cycles before timeout error (used only with PAUSE_TIMEOUT_EN)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       synchronous, active-high reset
//  iniciar       in   1       start request, sampled in INIT
//  ch_mask       in   NUM_CH  1 = channel participates; masked channels' flags ignored
//  almost_full   in   NUM_CH  per-channel almost-full flag
//  full          in   NUM_CH  per-channel full flag
//  almost_empty  in   NUM_CH  per-channel almost-empty flag
//  empty         in   NUM_CH  per-channel empty flag
//  continuar     out  1       producer may push (state ACTIVE)
//  pausa         out  1       producer must stall (state PAUSE)
//  idle          out  1       all enabled FIFOs drained (state IDLE)
//  error_full    out  1       overflow/timeout error (state ERROR)
//  error_ch      out  NUM_CH  sticky map of channels seen full while in IDLE/ACTIVE/PAUSE/ERROR
//  error_tmo     out  1       pause-timeout flag (sticky; 0 when macro absent)
//  estado        out  3       current state code (debug)
// BEHAVIOUR
//  - States (register actual[2:0]): RESET=000 INIT=001 IDLE=010 ACTIVE=011 PAUSE=100 ERROR=101.
//  - Codes 110/111 are illegal: next state RESET, all outputs 0 in that cycle.
//  - reset=1 at an edge: actual<=RESET, error_ch<=0, error_tmo<=0, pause counter<=0; overrides any state.
//  - Outputs are Moore decodes of actual; inputs sampled at edge k take effect right after edge k.
//  - Effective flags = flag & ch_mask. AF=|af, F=|f, ALL_E=&(empty|~mask), ALL_LOW=&(almost_empty|empty|~mask).
//  - Transitions (priority top-down inside each state):
//      RESET  -> INIT (unconditional once reset=0)
//      INIT   -> IDLE if iniciar=1, else stay
//      IDLE   -> ERROR if F; ACTIVE if !ALL_E; else stay
//      ACTIVE -> ERROR if F; PAUSE if AF; IDLE if ALL_E; else stay
//      PAUSE  -> ERROR if F; ACTIVE if !AF && ALL_LOW; else stay (hysteresis)
//      ERROR  -> stay until reset
//  - On any transition into ERROR via F: error_ch <= error_ch | (full & ch_mask); in ERROR keeps OR-ing.
//  - Outputs one-hot among continuar/pausa/idle/error_full; all 0 in RESET/INIT/illegal.
//  - ch_mask=0: ALL_E=1, AF=F=0 -> IDLE/ACTIVE settle in IDLE, never ERROR.
//  - Simultaneous full and almost_full: ERROR wins; iniciar ignored outside INIT.
// CONFIGURATION
//  PAUSE_TIMEOUT_EN defined: counter width $clog2(PAUSE_TMO+1); cleared on any non-PAUSE state,
//   +1 per PAUSE cycle; when it reaches PAUSE_TMO while still PAUSE, next state ERROR, error_tmo<=1,
//   error_ch unchanged. F has priority over timeout in the same cycle (both flags may set).
//  PAUSE_TIMEOUT_EN undefined: no counter, PAUSE may last forever, error_tmo tied 0.
// TESTING
//  1. reset=1 two cycles -> estado=000, all outputs 0; release -> 001 next edge, iniciar=1 -> 010, idle=1.
//  2. IDLE, empty=4'b1110 -> ACTIVE, continuar=1; almost_full=4'b0100 -> PAUSE, pausa=1.
//  3. PAUSE, drop almost_full, almost_empty=4'b0001 only -> stays PAUSE; almost_empty=4'b1111 -> ACTIVE.
//  4. ACTIVE, full=4'b1000 & almost_full=4'b1000 -> ERROR, error_full=1, error_ch=4'b1000; full=4'b0010 -> error_ch=4'b1010; reset -> 000, error_ch=0.
//  5. ch_mask=4'b0111, full=4'b1000 in ACTIVE -> no ERROR; force actual=3'b110 -> next RESET, outputs 0.
//  6. PAUSE_TIMEOUT_EN, PAUSE_TMO=16: hold almost_full 16 PAUSE cycles -> ERROR, error_tmo=1, error_ch=0; without macro stays PAUSE.

Source files
------------

// File: rtl/fsm_flow_ctrl_multi.sv
// fsm_flow_ctrl_multi: one global flow-control decision (continuar/pausa/idle/error_full)
// derived from the almost_full/full/almost_empty/empty flags of NUM_CH FIFOs, plus a
// sticky per-channel map of channels seen full.
// Optional feature: define PAUSE_TIMEOUT_EN to turn a PAUSE lasting PAUSE_TMO cycles into ERROR.
module fsm_flow_ctrl_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PAUSE_TMO = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] almost_full,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] almost_empty,
  input  logic [NUM_CH-1:0] empty,
  output logic              continuar,
  output logic              pausa,
  output logic              idle,
  output logic              error_full,
  output logic [NUM_CH-1:0] error_ch,
  output logic              error_tmo,
  output logic [2:0]        estado
);

  typedef enum logic [2:0] {
    StReset  = 3'b000,
    StInit   = 3'b001,
    StIdle   = 3'b010,
    StActive = 3'b011,
    StPause  = 3'b100,
    StError  = 3'b101
  } state_e;

  // Plain vector so the unused codes 110/111 stay representable and recoverable.
  logic [2:0]        actual;
  state_e            actual_d;
  logic [NUM_CH-1:0] error_ch_d;
  logic              any_af, any_f, all_e, all_low, tmo_hit;

  // Masked channels never contribute: they look empty, not full and not almost full.
  assign any_af  = |(almost_full & ch_mask);
  assign any_f   = |(full & ch_mask);
  assign all_e   = &(empty | ~ch_mask);
  assign all_low = &(almost_empty | empty | ~ch_mask);

  assign estado = actual;

`ifdef PAUSE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(PAUSE_TMO + 1);

  logic [CntW-1:0] pause_cnt, pause_cnt_inc;
  logic            error_tmo_q;

  assign pause_cnt_inc = pause_cnt + CntW'(1);
  // Fires on the PAUSE cycle whose count reaches PAUSE_TMO.
  assign tmo_hit       = (actual == StPause) && (pause_cnt_inc == CntW'(PAUSE_TMO));
  assign error_tmo     = error_tmo_q;

  // Pause residency counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_cnt   <= '0;
      error_tmo_q <= 1'b0;
    end else begin
      pause_cnt <= (actual == StPause) ? pause_cnt_inc : '0;
      if (tmo_hit) error_tmo_q <= 1'b1;
    end
  end
`else
  logic unused_pause_tmo;
  assign unused_pause_tmo = ^PAUSE_TMO;
  assign tmo_hit          = 1'b0;
  assign error_tmo        = 1'b0;
`endif

  // Next-state, error map update and Moore output decode.
  always_comb begin
    actual_d   = state_e'(actual);
    error_ch_d = error_ch;
    continuar  = 1'b0;
    pausa      = 1'b0;
    idle       = 1'b0;
    error_full = 1'b0;
    case (actual)
      StReset: actual_d = StInit;
      StInit: begin
        if (iniciar) actual_d = StIdle;
      end
      StIdle: begin
        idle       = 1'b1;
        error_ch_d = error_ch | (full & ch_mask);
        if (any_f)       actual_d = StError;
        else if (!all_e) actual_d = StActive;
      end
      StActive: begin
        continuar  = 1'b1;
        error_ch_d = error_ch | (full & ch_mask);
        if (any_f)       actual_d = StError;
        else if (any_af) actual_d = StPause;
        else if (all_e)  actual_d = StIdle;
      end
      StPause: begin
        pausa      = 1'b1;
        error_ch_d = error_ch | (full & ch_mask);
        if (any_f)                   actual_d = StError;
        else if (tmo_hit)            actual_d = StError;
        else if (!any_af && all_low) actual_d = StActive;
      end
      StError: begin
        error_full = 1'b1;
        error_ch_d = error_ch | (full & ch_mask);
      end
      default: actual_d = StReset;
    endcase
  end

  // State register and sticky error map.
  always_ff @(posedge clk) begin
    if (reset) begin
      actual   <= StReset;
      error_ch <= '0;
    end else begin
      actual   <= actual_d;
      error_ch <= error_ch_d;
    end
  end

endmodule

// File: tb/tb_fsm_flow_ctrl_multi.sv
// tb_fsm_flow_ctrl_multi: directed stimulus for fsm_flow_ctrl_multi, a flag-counting reference
// model compared every cycle, plus literal expectations at key points.
// Honours PAUSE_TIMEOUT_EN the same way the design does.
module tb_fsm_flow_ctrl_multi;
  localparam int N   = 4;
  localparam int TMO = 16;
`ifdef PAUSE_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, iniciar;
  logic [N-1:0] ch_mask, almost_full, full, almost_empty, empty;
  logic         continuar, pausa, idle, error_full, error_tmo;
  logic [N-1:0] error_ch;
  logic [2:0]   estado;
  logic [3:0]   outs;

  assign outs = {continuar, pausa, idle, error_full};

  always #5 clk = ~clk;

  fsm_flow_ctrl_multi #(.NUM_CH(N), .PAUSE_TMO(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .iniciar      (iniciar),
    .ch_mask      (ch_mask),
    .almost_full  (almost_full),
    .full         (full),
    .almost_empty (almost_empty),
    .empty        (empty),
    .continuar    (continuar),
    .pausa        (pausa),
    .idle         (idle),
    .error_full   (error_full),
    .error_ch     (error_ch),
    .error_tmo    (error_tmo),
    .estado       (estado)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: state as a number 0..5 (RESET..ERROR), decisions from channel counts.
  int           m_st  = 0;
  int           m_cnt = 0;
  logic [N-1:0] m_ech = '0;
  logic         m_tmo = 1'b0;
  logic         model_on = 1'b0;
  logic         inj_illegal = 1'b0;

  always @(posedge clk) begin
    int           nf, naf, nbusy, nhigh, nxt, cnt;
    logic [N-1:0] ech;
    logic         tmo;
    nf = 0; naf = 0; nbusy = 0; nhigh = 0;
    ech = m_ech;
    tmo = m_tmo;
    for (int i = 0; i < N; i++) begin
      if (ch_mask[i]) begin
        if (full[i]) nf++;
        if (almost_full[i]) naf++;
        if (!empty[i]) nbusy++;
        if (!(empty[i] || almost_empty[i])) nhigh++;
        if (full[i] && m_st >= 2) ech[i] = 1'b1;
      end
    end
    cnt = (m_st == 4) ? m_cnt + 1 : 0;
    nxt = m_st;
    if (inj_illegal) nxt = 0;
    else begin
      case (m_st)
        0: nxt = 1;
        1: if (iniciar) nxt = 2;
        2: if (nf > 0) nxt = 5; else if (nbusy > 0) nxt = 3;
        3: if (nf > 0) nxt = 5; else if (naf > 0) nxt = 4; else if (nbusy == 0) nxt = 2;
        4: if (nf > 0) nxt = 5;
           else if (TmoEn && cnt == TMO) nxt = 5;
           else if (naf == 0 && nhigh == 0) nxt = 3;
        default: nxt = m_st;
      endcase
      if (TmoEn && m_st == 4 && cnt == TMO) tmo = 1'b1;
    end
    if (reset) begin
      m_st  <= 0;
      m_cnt <= 0;
      m_ech <= '0;
      m_tmo <= 1'b0;
    end else begin
      m_st  <= nxt;
      m_cnt <= cnt;
      m_ech <= inj_illegal ? m_ech : ech;
      m_tmo <= tmo;
    end
  end

  // Every-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (model_on) begin
      check("model_cycle",
            {outs, error_ch, error_tmo, estado},
            {(m_st == 3), (m_st == 4), (m_st == 2), (m_st == 5), m_ech, m_tmo, 3'(m_st)});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; ch_mask = '1;
    almost_full = '0; full = '0; almost_empty = '1; empty = '1;
    tick();
    model_on = 1'b1;
    tick();
    check("reset_outs", outs, 4'b0000);
    check("reset_estado", estado, 3'b000);
    check("reset_error_ch", error_ch, 4'b0000);
    reset = 1'b0;
    tick();
    check("init_estado", estado, 3'b001);
    iniciar = 1'b1;
    tick();
    check("idle_estado", estado, 3'b010);
    check("idle_outs", outs, 4'b0010);
    iniciar = 1'b0;

    empty = 4'b1110;
    tick();
    check("active_outs", outs, 4'b1000);
    almost_full = 4'b0100;
    tick();
    check("pause_outs", outs, 4'b0100);

    almost_full = '0; empty = '0; almost_empty = 4'b0001;
    tick();
    check("pause_hysteresis", outs, 4'b0100);
    almost_empty = 4'b1111;
    tick();
    check("pause_exit", outs, 4'b1000);
    almost_empty = '0;

    full = 4'b1000; almost_full = 4'b1000;
    tick();
    check("error_outs", outs, 4'b0001);
    check("error_ch_first", error_ch, 4'b1000);
    full = 4'b0010; almost_full = '0;
    tick();
    check("error_ch_accum", error_ch, 4'b1010);
    check("error_sticky", outs, 4'b0001);
    full = '0; reset = 1'b1;
    tick();
    check("error_reset_estado", estado, 3'b000);
    check("error_reset_map", error_ch, 4'b0000);
    reset = 1'b0; iniciar = 1'b1;
    tick();
    tick();
    iniciar = 1'b0;
    tick();
    check("reactive_outs", outs, 4'b1000);

    ch_mask = 4'b0111; full = 4'b1000;
    tick();
    check("masked_full_outs", outs, 4'b1000);
    check("masked_full_map", error_ch, 4'b0000);
    ch_mask = 4'b0000;
    tick();
    check("mask_zero_idle", outs, 4'b0010);
    tick();
    check("mask_zero_stays", outs, 4'b0010);
    ch_mask = 4'b0111;
    tick();
    check("unmask_active", outs, 4'b1000);

    force dut.actual = 3'b110;
    inj_illegal = 1'b1;
    #1;
    check("illegal_outs", {outs, error_tmo}, 5'b00000);
    release dut.actual;
    tick();
    inj_illegal = 1'b0;
    check("illegal_recover", estado, 3'b000);

    full = '0; ch_mask = '1; iniciar = 1'b1;
    tick();
    tick();
    iniciar = 1'b0;
    tick();
    almost_full = 4'b0001;
    tick();
    check("tmo_pause_entry", outs, 4'b0100);
    repeat (TMO - 1) tick();
    check("tmo_pause_held", outs, 4'b0100);
    tick();
`ifdef PAUSE_TIMEOUT_EN
    check("tmo_error_outs", outs, 4'b0001);
    check("tmo_flag", error_tmo, 1'b1);
`else
    check("tmo_absent_pause", outs, 4'b0100);
    check("tmo_flag_absent", error_tmo, 1'b0);
`endif
    check("tmo_error_map", error_ch, 4'b0000);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
